// File: rtl/fpu_operand_stager.sv
// Converts an IEEE-754 single pair into the 1/6/25 (bias 31) FPU word format and holds it steady.
// Build option FPU_STAGER_NAN_EN: NaN keeps its mantissa and raises nan_flag instead of overflowing.
module fpu_operand_stager #(
  parameter int HOLD_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        clear_flags,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_busy,
  output logic        op_done,
  output logic [3:0]  flags,
  output logic [3:0]  sticky_flags,
  output logic        nan_flag,
  output logic [1:0]  dbg_state
);
  // Handshake: a pair transfers on a rising edge where in_valid && in_ready; in_valid while
  // in_ready is low is ignored and the source must keep the pair stable until it transfers.

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic        ovf;
    logic        unf;
`ifdef FPU_STAGER_NAN_EN
    logic        nan;
`endif
  } conv_t;

  function automatic conv_t convert(input logic [31:0] x);
    conv_t       r;
    logic        s;
    logic [7:0]  e8;
    logic [22:0] f;
    logic [7:0]  eb;
    s  = x[31];
    e8 = x[30:23];
    f  = x[22:0];
    eb = e8 - 8'd96;
    r  = '0;
    r.word = {s, 31'd0};
`ifdef FPU_STAGER_NAN_EN
    if (e8 == 8'hFF && f != 23'd0) begin
      r.word = {s, 6'h3F, f, 2'b00};
      r.nan  = 1'b1;
    end else
`endif
    if (e8 > 8'd159) begin
      // Includes infinity, and NaN when the NaN option is off.
      r.word = {s, 6'h3F, 25'd0};
      r.ovf  = 1'b1;
    end else if (e8 >= 8'd96) begin
      r.word = {s, eb[5:0], f, 2'b00};
    end else if (e8 != 8'd0 || f != 23'd0) begin
      r.unf = 1'b1;
    end
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q, b_q;
  logic             upd_q;
  conv_t            ca, cb;

  assign ca        = convert(a_q);
  assign cb        = convert(b_q);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    op_busy   = 1'b0;
    op_done   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: state_nxt = HOLD;
      HOLD: begin
        op_busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
          op_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      flags <= '0;
      cnt   <= '0;
      upd_q <= 1'b0;
    end else begin
      upd_q <= (state == CONV);
      if (state == IDLE && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state == CONV) begin
        op_a  <= ca.word;
        op_b  <= cb.word;
        flags <= {ca.ovf, ca.unf, cb.ovf, cb.unf};
        cnt   <= CNT_W'(HOLD_CYCLES);
      end else if (state == HOLD) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Sticky state folds in the pair one cycle after CONV; a same-cycle clear takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            sticky_flags <= '0;
    else if (clear_flags) sticky_flags <= '0;
    else if (upd_q)       sticky_flags <= sticky_flags | flags;
  end

`ifdef FPU_STAGER_NAN_EN
  logic nan_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)               nan_q <= 1'b0;
    else if (state == CONV)  nan_q <= ca.nan | cb.nan;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            nan_flag <= 1'b0;
    else if (clear_flags) nan_flag <= 1'b0;
    else if (upd_q)       nan_flag <= nan_flag | nan_q;
  end
`else
  assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_operand_stager.sv
// Bench for fpu_operand_stager: directed vector table, randomized pairs against a value-level
// model, back-to-back, clear-flag collision and reset-during-hold sequences.
module tb_fpu_operand_stager;
  localparam int HC = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        clear_flags = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready, op_busy, op_done, nan_flag;
  logic [31:0] op_a, op_b;
  logic [3:0]  flags, sticky_flags;
  logic [1:0]  dbg_state;

  fpu_operand_stager #(.HOLD_CYCLES(HC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .clear_flags(clear_flags),
    .op_a(op_a), .op_b(op_b), .op_busy(op_busy), .op_done(op_done),
    .flags(flags), .sticky_flags(sticky_flags), .nan_flag(nan_flag),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Scoreboard entry: {nan, flags[3:0], op_a, op_b}
  logic [68:0] exp_q[$];
  logic [3:0]  sticky_m = '0;
  logic        nan_m = 1'b0;
  logic [31:0] last_a = '0;

  typedef struct {
    logic [31:0] a, b, ea, eb;
    logic [3:0]  fl;
    logic        nan;
    logic        clr;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: unbiased exponent must fit in [-31, 32] to be representable.
  function automatic logic [34:0] model(input logic [31:0] x);
    int          e, ue;
    logic [31:0] w;
    logic        ovf, unf, nan;
    e = int'(x[30:23]);
    ue = e - 127;
    ovf = 1'b0; unf = 1'b0; nan = 1'b0;
    w = {x[31], 31'd0};
    if (e == 255 && x[22:0] != 23'd0) begin
`ifdef FPU_STAGER_NAN_EN
      nan = 1'b1;
      w = w | (32'd63 << 25) | (32'(x[22:0]) << 2);
`else
      ovf = 1'b1;
      w = w | (32'd63 << 25);
`endif
    end else if (e == 0 && x[22:0] == 23'd0) begin
      w = w;
    end else if (ue < -31) begin
      unf = 1'b1;
    end else if (ue > 32) begin
      ovf = 1'b1;
      w = w | (32'd63 << 25);
    end else begin
      w = w | (32'(ue + 31) << 25) | (32'(x[22:0]) << 2);
    end
    return {nan, ovf, unf, w};
  endfunction

  task automatic push_model(input logic [31:0] a, input logic [31:0] b);
    logic [34:0] ma, mb;
    ma = model(a);
    mb = model(b);
    exp_q.push_back({ma[34] | mb[34], ma[33], ma[32], mb[33], mb[32], ma[31:0], mb[31:0]});
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [7:0]  e;
    case ($urandom_range(0, 5))
      0: e = 8'($urandom_range(96, 159));
      1: e = 8'($urandom_range(0, 95));
      2: e = 8'($urandom_range(160, 255));
      3: e = 8'($urandom_range(94, 98));
      4: e = 8'($urandom_range(157, 161));
      default: e = 8'hFF;
    endcase
    r = $urandom;
    r[30:23] = e;
    if ($urandom_range(0, 3) == 0) r[22:0] = '0;
    return r;
  endfunction

  // Driver: returns at the start of the CONV cycle with in_valid still high.
  task automatic start_pair(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 4 * HC) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clock);
  endtask

  // Checks CONV, every HOLD cycle and the following IDLE cycle against the next scoreboard entry.
  task automatic watch_hold(input logic clr_c1);
    logic [68:0] e;
    logic        en;
    logic [3:0]  ef;
    logic [31:0] ea, eb;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    {en, ef, ea, eb} = e;
    chk("conv_ready", in_ready, 0);
    chk("conv_busy", op_busy, 0);
    chk("conv_op_a_held", op_a, last_a);
    @(negedge clock);
    if (clr_c1) clear_flags = 1'b1;
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("flags", flags, ef);
    for (int c = 1; c <= HC; c++) begin
      chk("hold_busy", op_busy, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_done", op_done, (c == HC) ? 1 : 0);
      chk("hold_op_a_stable", op_a, ea);
      @(negedge clock);
      clear_flags = 1'b0;
    end
    chk("idle_ready", in_ready, 1);
    chk("idle_busy", op_busy, 0);
    chk("idle_done", op_done, 0);
    if (clr_c1) begin
      sticky_m = '0;
      nan_m = 1'b0;
    end else begin
      sticky_m = sticky_m | ef;
      nan_m = nan_m | en;
    end
    chk("sticky_flags", sticky_flags, sticky_m);
    chk("nan_flag", nan_flag, nan_m);
    last_a = ea;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(negedge clock);
    clear_flags = 1'b0;
    sticky_m = '0;
    nan_m = 1'b0;
    chk("clear_sticky", sticky_flags, 0);
    chk("clear_nan", nan_flag, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_busy"}, op_busy, 0);
    chk({tag, "_done"}, op_done, 0);
    chk({tag, "_op_a"}, op_a, 0);
    chk({tag, "_op_b"}, op_b, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_sticky"}, sticky_flags, 0);
    chk({tag, "_nan"}, nan_flag, 0);
  endtask

  initial begin
    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h3E000000, 32'h40000000, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{32'hBFC00000, 32'h00000000, 32'hBF000000, 32'h00000000, 4'b0000, 1'b0, 1'b0};
    vecs[2] = '{32'h60AD78EC, 32'h1E3CE508, 32'h7E000000, 32'h00000000, 4'b1001, 1'b0, 1'b1};
`ifdef FPU_STAGER_NAN_EN
    vecs[3] = '{32'h7FC00000, 32'h3F800000, 32'h7F000000, 32'h3E000000, 4'b0000, 1'b1, 1'b1};
`else
    vecs[3] = '{32'h7FC00000, 32'h3F800000, 32'h7E000000, 32'h3E000000, 4'b1000, 1'b0, 1'b1};
`endif
    vecs[4] = '{32'h4F800001, 32'hB0000000, 32'h7E000004, 32'h80000000, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{32'hD0000000, 32'hAFFFFFFF, 32'hFE000000, 32'h80000000, 4'b1001, 1'b0, 1'b0};
    vecs[6] = '{32'h00000001, 32'hFF800000, 32'h00000000, 32'hFE000000, 4'b0110, 1'b0, 1'b0};
    vecs[7] = '{32'h80000000, 32'h3FFFFFFF, 32'h80000000, 32'h3FFFFFFC, 4'b0000, 1'b0, 1'b0};

    @(negedge clock);
    @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({vecs[i].nan, vecs[i].fl, vecs[i].ea, vecs[i].eb});
      start_pair(vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      watch_hold(1'b0);
      if (vecs[i].clr) pulse_clear();
    end

    // Clear landing in the same cycle as the sticky update
    push_model(32'h60AD78EC, 32'h1E3CE508);
    start_pair(32'h60AD78EC, 32'h1E3CE508);
    in_valid = 1'b0;
    watch_hold(1'b1);

    // Back-to-back with in_valid held high
    push_model(32'h3F800000, 32'h40000000);
    push_model(32'hBFC00000, 32'h00000000);
    start_pair(32'h3F800000, 32'h40000000);
    in_a = 32'hBFC00000;
    in_b = 32'h00000000;
    watch_hold(1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    watch_hold(1'b0);

    // Randomized pairs against the model
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      push_model(ra, rb);
      start_pair(ra, rb);
      in_valid = 1'b0;
      watch_hold($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Reset during HOLD aborts without op_done
    start_pair(32'h60AD78EC, 32'h3F800000);
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    chk("pre_reset_busy", op_busy, 1);
    #1 reset = 1'b1;
    #1 check_reset_values("async_reset");
    @(negedge clock);
    reset = 1'b0;
    sticky_m = '0;
    nan_m = 1'b0;
    last_a = '0;
    begin
      int seen = 0;
      for (int c = 0; c < HC + 4; c++) begin
        @(negedge clock);
        if (op_done) seen++;
      end
      chk("no_done_after_reset", seen, 0);
    end
    check_reset_values("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
